// File: rtl/pc_sequencer.sv
// Program-counter sequencer with return-address-stack control and halt/fault states.
// Define PC_SEQ_FAULT_TRAP_EN to trap stack overflow/underflow into FAULT instead of degrading.
module pc_sequencer #(
  parameter int          D           = 12,
  parameter int          STACK_DEPTH = 8,
  parameter int unsigned START_ADDR  = 0,
  localparam int         DW          = $clog2(STACK_DEPTH + 1)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          stall,
  input  logic          halt_req,
  input  logic          branch_taken,
  input  logic [D-1:0]  branch_target,
  input  logic          call,
  input  logic          ret,
  input  logic [D-1:0]  ras_target,
  output logic [D-1:0]  pc,
  output logic          ras_push,
  output logic          ras_pop,
  output logic [D-1:0]  ras_push_addr,
  output logic [DW-1:0] depth,
  output logic          fault,
  output logic          done
);

  typedef enum logic [1:0] {
    S_RUN,
    S_RET_WAIT,
    S_HALT,
    S_FAULT
  } state_t;

  state_t        r_state;
  logic [D-1:0]  r_pc;
  logic [DW-1:0] r_depth;
  logic          r_fault;
  logic          r_done;

  logic          w_active;
  logic          w_full;
  logic          w_empty;
  logic [D-1:0]  w_pc_inc;

  assign w_active = !reset && (r_state == S_RUN) && !stall;
  assign w_full   = (r_depth == DW'(STACK_DEPTH));
  assign w_empty  = (r_depth == '0);
  assign w_pc_inc = r_pc + D'(1);

  // Strobes follow the same priority as the state update; ret shadows call.
  always_comb begin
    ras_push = 1'b0;
    ras_pop  = 1'b0;
    if (w_active && !halt_req) begin
      if (ret) begin
        ras_pop = !w_empty;
      end else if (call) begin
        ras_push = !w_full;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_RUN;
      r_pc    <= D'(START_ADDR);
      r_depth <= '0;
      r_fault <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      case (r_state)
        S_RUN: begin
          if (!stall) begin
            if (halt_req) begin
              r_state <= S_HALT;
              r_done  <= 1'b1;
            end else if (ret) begin
              if (!w_empty) begin
                r_depth <= r_depth - DW'(1);
                r_state <= S_RET_WAIT;
              end else begin
`ifdef PC_SEQ_FAULT_TRAP_EN
                r_fault <= 1'b1;
                r_state <= S_FAULT;
`else
                r_pc    <= w_pc_inc;
`endif
              end
            end else if (call) begin
              if (!w_full) begin
                r_depth <= r_depth + DW'(1);
                r_pc    <= branch_target;
              end else begin
`ifdef PC_SEQ_FAULT_TRAP_EN
                r_fault <= 1'b1;
                r_state <= S_FAULT;
`else
                r_pc    <= branch_target;
`endif
              end
            end else if (branch_taken) begin
              r_pc <= branch_target;
            end else begin
              r_pc <= w_pc_inc;
            end
          end
        end
        // Stack read data is valid exactly one cycle after the pop strobe.
        S_RET_WAIT: begin
          r_pc    <= ras_target;
          r_state <= S_RUN;
        end
        S_HALT, S_FAULT: begin
          r_state <= r_state;
        end
        default: begin
          r_state <= S_RUN;
        end
      endcase
    end
  end

  assign pc            = r_pc;
  assign depth         = r_depth;
  assign fault         = r_fault;
  assign done          = r_done;
  assign ras_push_addr = w_pc_inc;

endmodule

// File: tb/tb_pc_sequencer.sv
// Scoreboard bench for pc_sequencer: stimulus queues hand-computed expectations, monitor compares.
// Expectations for stack overflow/underflow follow PC_SEQ_FAULT_TRAP_EN when defined.
module tb_pc_sequencer;

  logic        clk = 1'b0;
  logic        reset;
  logic        stall;
  logic        halt_req;
  logic        branch_taken;
  logic [11:0] branch_target;
  logic        call;
  logic        ret;
  logic [11:0] ras_target;
  logic [11:0] pc;
  logic        ras_push;
  logic        ras_pop;
  logic [11:0] ras_push_addr;
  logic [3:0]  depth;
  logic        fault;
  logic        done;

  typedef struct {
    logic [11:0] pc;
    logic [3:0]  dep;
    logic        push;
    logic        pop;
    logic        done;
    logic        fault;
    logic [11:0] paddr;
    string       name;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_errors = 0;
  bit   stim_done = 1'b0;

  always #5 clk = ~clk;

  pc_sequencer #(.D(12), .STACK_DEPTH(8), .START_ADDR(0)) dut (
    .clk(clk), .reset(reset), .stall(stall), .halt_req(halt_req),
    .branch_taken(branch_taken), .branch_target(branch_target),
    .call(call), .ret(ret), .ras_target(ras_target),
    .pc(pc), .ras_push(ras_push), .ras_pop(ras_pop),
    .ras_push_addr(ras_push_addr), .depth(depth), .fault(fault), .done(done)
  );

  task automatic check(input string what, input string field, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_errors++;
      $display("FAIL %s.%s: got 0x%0h, required 0x%0h", what, field, act, req);
    end
  endtask

  // Inputs change 1ns after the edge; the queued entry describes outputs seen until the next edge.
  task automatic step(input logic rst, input logic st, input logic hr, input logic br,
                      input logic cl, input logic rt, input logic [11:0] tgt, input logic [11:0] rast,
                      input logic [11:0] e_pc, input logic [3:0] e_dep, input logic e_push,
                      input logic e_pop, input logic e_done, input logic e_fault,
                      input logic [11:0] e_paddr, input string nm);
    exp_t e;
    @(posedge clk);
    #1;
    reset = rst; stall = st; halt_req = hr; branch_taken = br;
    call = cl; ret = rt; branch_target = tgt; ras_target = rast;
    e.pc = e_pc; e.dep = e_dep; e.push = e_push; e.pop = e_pop;
    e.done = e_done; e.fault = e_fault; e.paddr = e_paddr; e.name = nm;
    exp_q.push_back(e);
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        $display("txn %-10s pc=%03h depth=%0d push=%0b pop=%0b done=%0b fault=%0b",
                 e.name, pc, depth, ras_push, ras_pop, done, fault);
        check(e.name, "pc", 32'(pc), 32'(e.pc));
        check(e.name, "depth", 32'(depth), 32'(e.dep));
        check(e.name, "ras_push", 32'(ras_push), 32'(e.push));
        check(e.name, "ras_pop", 32'(ras_pop), 32'(e.pop));
        check(e.name, "done", 32'(done), 32'(e.done));
        check(e.name, "fault", 32'(fault), 32'(e.fault));
        if (e.push) check(e.name, "push_addr", 32'(ras_push_addr), 32'(e.paddr));
      end
    end
  end

  initial begin : stimulus
    logic [11:0] t;
    reset = 1'b1; stall = 1'b0; halt_req = 1'b0; branch_taken = 1'b0;
    call = 1'b0; ret = 1'b0; branch_target = '0; ras_target = '0;
    repeat (2) @(posedge clk);

    //   rst st hr br cl rt  tgt     rast    e_pc    dep push pop done fault paddr
    step(1, 0, 0, 0, 0, 0, 12'h000, 12'h000, 12'h000, 0, 0, 0, 0, 0, 12'h000, "reset");
    for (int i = 0; i < 6; i++)
      step(0, 0, 0, 0, 0, 0, 12'h000, 12'h000, 12'(i), 0, 0, 0, 0, 0, 12'h000, "idle");
    step(0, 0, 0, 1, 0, 0, 12'h010, 12'h000, 12'h006, 0, 0, 0, 0, 0, 12'h000, "branch");
    step(0, 0, 0, 0, 1, 0, 12'h200, 12'h000, 12'h010, 0, 1, 0, 0, 0, 12'h011, "call");
    step(0, 0, 0, 0, 0, 1, 12'h000, 12'h000, 12'h200, 1, 0, 1, 0, 0, 12'h000, "ret");
    step(0, 1, 0, 0, 1, 0, 12'h000, 12'h011, 12'h200, 0, 0, 0, 0, 0, 12'h000, "ret_wait");
    step(0, 0, 0, 0, 0, 0, 12'h000, 12'h000, 12'h011, 0, 0, 0, 0, 0, 12'h000, "returned");
    step(0, 0, 0, 1, 0, 0, 12'hFFE, 12'h000, 12'h012, 0, 0, 0, 0, 0, 12'h000, "br_top");
    step(0, 0, 0, 0, 0, 0, 12'h000, 12'h000, 12'hFFE, 0, 0, 0, 0, 0, 12'h000, "seq_ffe");
    step(0, 0, 0, 0, 0, 0, 12'h000, 12'h000, 12'hFFF, 0, 0, 0, 0, 0, 12'h000, "seq_fff");
    step(0, 0, 0, 0, 0, 0, 12'h000, 12'h000, 12'h000, 0, 0, 0, 0, 0, 12'h000, "wrap");
    step(0, 0, 0, 0, 1, 0, 12'h100, 12'h000, 12'h001, 0, 1, 0, 0, 0, 12'h002, "call2");
    step(0, 1, 0, 1, 1, 1, 12'h300, 12'h000, 12'h100, 1, 0, 0, 0, 0, 12'h000, "stall_a");
    step(0, 1, 0, 1, 1, 1, 12'h300, 12'h000, 12'h100, 1, 0, 0, 0, 0, 12'h000, "stall_b");
    step(0, 0, 0, 1, 1, 1, 12'h300, 12'h000, 12'h100, 1, 0, 1, 0, 0, 12'h000, "prio_ret");
    step(0, 0, 0, 0, 0, 0, 12'h000, 12'h002, 12'h100, 0, 0, 0, 0, 0, 12'h000, "ret_wait2");
    step(0, 0, 0, 0, 0, 0, 12'h000, 12'h000, 12'h002, 0, 0, 0, 0, 0, 12'h000, "returned2");
    step(0, 0, 0, 0, 1, 1, 12'h400, 12'h000, 12'h003, 0, 0, 0, 0, 0, 12'h000, "underflow");
`ifdef PC_SEQ_FAULT_TRAP_EN
    step(0, 0, 0, 0, 0, 0, 12'h000, 12'h000, 12'h003, 0, 0, 0, 0, 1, 12'h000, "uf_after");
    step(1, 0, 0, 0, 0, 0, 12'h000, 12'h000, 12'h003, 0, 0, 0, 0, 1, 12'h000, "uf_reset");
`else
    step(0, 0, 0, 0, 0, 0, 12'h000, 12'h000, 12'h004, 0, 0, 0, 0, 0, 12'h000, "uf_after");
    step(1, 0, 0, 0, 0, 0, 12'h000, 12'h000, 12'h005, 0, 0, 0, 0, 0, 12'h000, "uf_reset");
`endif

    // Nine calls into an eight-entry stack; the ninth is the overflow.
    for (int i = 0; i < 9; i++) begin
      t = (i == 0) ? 12'h000 : 12'(12'h100 + 12'h010 * (i - 1));
      step(0, 0, 0, 0, 1, 0, 12'(12'h100 + 12'h010 * i), 12'h000, t, 4'(i),
           (i < 8) ? 1'b1 : 1'b0, 0, 0, 0, t + 12'h001, "call_n");
    end
`ifdef PC_SEQ_FAULT_TRAP_EN
    step(0, 0, 0, 1, 0, 0, 12'h555, 12'h000, 12'h170, 8, 0, 0, 0, 1, 12'h000, "ovf_after");
    step(1, 0, 0, 0, 0, 0, 12'h000, 12'h000, 12'h170, 8, 0, 0, 0, 1, 12'h000, "ovf_reset");
`else
    step(0, 0, 0, 1, 0, 0, 12'h555, 12'h000, 12'h180, 8, 0, 0, 0, 0, 12'h000, "ovf_after");
    step(1, 0, 0, 0, 0, 0, 12'h000, 12'h000, 12'h555, 8, 0, 0, 0, 0, 12'h000, "ovf_reset");
`endif

    step(0, 0, 0, 0, 1, 0, 12'h040, 12'h000, 12'h000, 0, 1, 0, 0, 0, 12'h001, "call3");
    step(0, 0, 0, 0, 0, 1, 12'h000, 12'h000, 12'h040, 1, 0, 1, 0, 0, 12'h000, "ret3");
    step(1, 0, 0, 0, 0, 0, 12'h000, 12'h777, 12'h040, 0, 0, 0, 0, 0, 12'h000, "rst_rwait");
    step(0, 0, 1, 0, 1, 0, 12'h123, 12'h000, 12'h000, 0, 0, 0, 0, 0, 12'h000, "halt");
    step(0, 0, 0, 1, 1, 1, 12'h123, 12'h000, 12'h000, 0, 0, 0, 1, 0, 12'h000, "halted_a");
    step(0, 0, 0, 0, 0, 0, 12'h000, 12'h000, 12'h000, 0, 0, 0, 1, 0, 12'h000, "halted_b");
    step(1, 0, 0, 0, 0, 0, 12'h000, 12'h000, 12'h000, 0, 0, 0, 1, 0, 12'h000, "halt_rst");
    step(0, 0, 0, 0, 0, 0, 12'h000, 12'h000, 12'h000, 0, 0, 0, 0, 0, 12'h000, "restart");
    stim_done = 1'b1;
  end

  initial begin : finisher
    wait (stim_done);
    for (int i = 0; i < 10 && exp_q.size() != 0; i++) @(negedge clk);
    @(posedge clk);
    if (exp_q.size() != 0) begin
      n_checks++;
      n_errors++;
      $display("FAIL drain: got %0d pending, required 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/pc_sequencer.md
PC_SEQUENCER -- requirements
Module: pc_sequencer

Interface
REQ-001 SHALL have parameter D, default 12, PC/address width in bits.
REQ-002 SHALL have parameter STACK_DEPTH, default 8, capacity of the attached return-address stack in entries.
REQ-003 SHALL have parameter START_ADDR, default 0, PC value loaded on reset.
REQ-004 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-005 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-006 SHALL have port stall  input  1  freezes sequencing for the cycle.
REQ-007 SHALL have port halt_req  input  1  request to stop fetching.
REQ-008 SHALL have port branch_taken  input  1  redirect PC to branch_target.
REQ-009 SHALL have port branch_target  input  D  branch destination.
REQ-010 SHALL have port call  input  1  subroutine call to branch_target, return address pushed.
REQ-011 SHALL have port ret  input  1  subroutine return, target popped from stack.
REQ-012 SHALL have port ras_target  input  D  popped address from stack, valid the cycle after ras_pop.
REQ-013 SHALL have port pc  output  D  registered current PC.
REQ-014 SHALL have port ras_push / ras_pop  output  1 each  single-cycle combinational stack strobes.
REQ-015 SHALL have port ras_push_addr  output  D  return address (pc+1 mod 2^D), valid with ras_push.
REQ-016 SHALL have port depth  output  $clog2(STACK_DEPTH+1)  registered stack occupancy.
REQ-017 SHALL have port fault  output  1  registered; overflow/underflow occurred.
REQ-018 SHALL have port done  output  1  registered; high in HALT.

Function
REQ-019 SHALL implement states RUN, RET_WAIT, HALT, FAULT.
REQ-020 In RUN with stall=1: pc, depth, state held; ras_push=ras_pop=0; all requests ignored.
REQ-021 In RUN, stall=0, requests SHALL be resolved by priority halt_req > ret > call > branch_taken > sequential.
REQ-022 halt_req: pc held, next state HALT, done=1 from next cycle.
REQ-023 ret with depth>0: ras_pop=1 this cycle, depth-1, pc held, next state RET_WAIT.
REQ-024 RET_WAIT: pc <= ras_target, next state RUN; stall and all requests ignored; exactly one cycle.
REQ-025 call with depth<STACK_DEPTH: ras_push=1, ras_push_addr=pc+1, depth+1, pc <= branch_target.
REQ-026 branch_taken: pc <= branch_target; no stack activity.
REQ-027 Otherwise: pc <= pc+1, modulo 2^D (max value wraps to 0, no flag).
REQ-028 depth SHALL never exceed STACK_DEPTH nor go below 0.
REQ-029 ras_push and ras_pop SHALL never both be 1 in one cycle.
REQ-030 HALT and FAULT: absorbing until reset; pc held; strobes 0.
REQ-031 Overflow (call at depth=STACK_DEPTH) and underflow (ret at depth=0): behaviour per REQ-034/035.

Reset
REQ-032 reset=1 at a rising edge SHALL set pc=START_ADDR, depth=0, fault=0, done=0, state RUN, from any state including RET_WAIT (pending pop discarded).
REQ-033 reset SHALL take priority over all other inputs; ras_push/ras_pop=0 while reset=1.

Configuration
REQ-034 With PC_SEQ_FAULT_TRAP_EN defined: overflow/underflow SHALL assert no strobe, hold pc and depth, set fault=1, enter FAULT.
REQ-035 Without PC_SEQ_FAULT_TRAP_EN: overflow SHALL suppress push, keep depth, still jump pc <= branch_target; underflow SHALL treat ret as sequential (pc+1); fault tied 0; FAULT state unreachable.

Verification
REQ-036 Reset, 5 idle cycles -> pc 0,1,2,3,4,5; depth 0; done 0.
REQ-037 pc=0x010, call target 0x200 -> ras_push=1, ras_push_addr=0x011, depth 1, next pc 0x200; later ret, ras_target=0x011 -> ras_pop one cycle, pc 0x200 held, then pc 0x011, depth 0.
REQ-038 D=12, pc=0xFFF, no request -> pc 0x000 next cycle, fault 0.
REQ-039 9 calls with STACK_DEPTH=8 -> 8 pushes, depth 8; 9th: macro defined fault=1, state FAULT, pc frozen; macro undefined no push, pc=target, fault 0.
REQ-040 stall=1 with call, ret and branch_taken all high -> pc/depth unchanged, no strobes; release stall -> ret taken first (priority).
REQ-041 reset asserted during RET_WAIT -> next cycle pc=START_ADDR, depth 0, state RUN; halt_req then -> done=1, pc frozen until reset.
